// File: rtl/tcb_sched_pkg.sv
// Shared types and constants for the TCB inference scheduler.
package tcb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int IMG_W = 968;
    localparam int NUM_W = 8;
    localparam logic [NUM_W-1:0] ERR_NUMBER = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after `last`
// in cyclic order, returning a one-hot grant.
module rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Walk last+1 .. last+N_REQ so `last` itself has the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcb_infer_sched.sv
// Round-robin scheduler sharing one TCB classifier between N_REQ image
// requesters, with a watchdog that aborts a stalled network.
module tcb_infer_sched #(
    parameter int  N_REQ   = 4,
    parameter int  IMG_W   = 968,
    parameter int  NUM_W   = 8,
    parameter int  TIMEOUT = 1023,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IMG_W-1:0] req_img,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [NUM_W-1:0]       rsp_number,
    output logic                   rsp_err,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [IMG_W-1:0]       net_img,
    output logic                   net_valid,
    input  logic                   net_ready,
    input  logic                   net_done,
    input  logic [NUM_W-1:0]       net_number,
    output logic                   net_abort,
    output logic                   busy
);
    import tcb_sched_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IMG_W-1:0] grant_img;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic [IMG_W-1:0] img_q;
    logic [WD_W-1:0]  wd_q;
    logic [NUM_W-1:0] rsp_number_q;
    logic             rsp_err_q;
    logic             wd_expired;
    logic             take_grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        grant_img = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
                grant_img = req_img[i*IMG_W +: IMG_W];
            end
        end
    end

    assign take_grant = (state_q == IDLE) && (grant != '0);
    assign wd_expired = (wd_q == WD_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant != '0) state_d = ISSUE;
            ISSUE:   if (net_ready) state_d = WAIT;
            WAIT:    if (net_done || wd_expired) state_d = RESP;
            RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        net_valid = 1'b0;
        net_abort = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
            end
            ISSUE:   net_valid = 1'b1;
            // A result arriving on the last watchdog cycle beats the abort.
            WAIT:    net_abort = wd_expired && !net_done;
            RESP:    rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
        // req_ready is combinational from req_valid; keep it quiet during reset.
        if (!rst_n) req_ready = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q        <= '0;
            owner_q      <= '0;
            last_q       <= IDX_W'(N_REQ - 1);
            wd_q         <= '0;
            rsp_number_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (take_grant) begin
                img_q   <= grant_img;
                owner_q <= grant_idx;
            end
            if (state_q == ISSUE && net_ready) begin
                wd_q <= '0;
            end else if (state_q == WAIT) begin
                wd_q <= wd_q + 1'b1;
            end
            if (state_q == WAIT) begin
                if (net_done) begin
                    rsp_number_q <= net_number;
                    rsp_err_q    <= 1'b0;
                end else if (wd_expired) begin
                    rsp_number_q <= NUM_W'(ERR_NUMBER);
                    rsp_err_q    <= 1'b1;
                end
            end
            if (state_q == RESP && rsp_ready[owner_q]) begin
                last_q <= owner_q;
            end
        end
    end

    assign net_img    = img_q;
    assign rsp_number = rsp_number_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_tcb_infer_sched.sv
// Scoreboard bench for tcb_infer_sched: the bench plays requesters and network,
// pushes expected responses, and a monitor checks each response handshake.
module tb_tcb_infer_sched;

    localparam int N_REQ   = 4;
    localparam int IMG_W   = 968;
    localparam int NUM_W   = 8;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*IMG_W-1:0] req_img;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [NUM_W-1:0]       rsp_number;
    logic                   rsp_err;
    logic [N_REQ-1:0]       rsp_ready;
    logic [IMG_W-1:0]       net_img;
    logic                   net_valid;
    logic                   net_ready;
    logic                   net_done;
    logic [NUM_W-1:0]       net_number;
    logic                   net_abort;
    logic                   busy;

    tcb_infer_sched #(
        .N_REQ(N_REQ), .IMG_W(IMG_W), .NUM_W(NUM_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_img(req_img), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_number(rsp_number), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .net_img(net_img), .net_valid(net_valid), .net_ready(net_ready),
        .net_done(net_done), .net_number(net_number), .net_abort(net_abort),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_REQ-1:0] owner;
        logic [NUM_W-1:0] num;
        logic             err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [IMG_W-1:0] mk_img(input int s);
        logic [IMG_W-1:0] v;
        v = '0;
        for (int k = 0; k < IMG_W / 8; k++) v[k*8 +: 8] = 8'(s * 37 + k * 3);
        return v;
    endfunction

    // Monitor: every completed response handshake pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (rsp_valid & rsp_ready) != '0) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("rsp_owner", 64'(rsp_valid), 64'(mon_e.owner));
                    check("rsp_number", 64'(rsp_number), 64'(mon_e.num));
                    check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    // done_wait: >=0 cycles in WAIT before net_done, -1 let it time out, -2 stop in WAIT.
    task automatic serve(input int r, input bit drop, input int rdy_wait, input int done_wait,
                         input logic [NUM_W-1:0] num, output int gcyc);
        logic [N_REQ-1:0] exp_oh;
        logic [IMG_W-1:0] exp_img;
        bit               got;
        exp_oh  = N_REQ'(1) << r;
        exp_img = mk_img(r + 1);
        got     = 1'b0;
        gcyc    = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            check("grant_wait", 64'd0, 64'd1);
            return;
        end
        gcyc = cyc;
        check("grant", 64'(req_ready), 64'(exp_oh));
        @(posedge clk); #1;
        if (drop) req_valid[r] = 1'b0;
        for (int i = 0; i < rdy_wait; i++) begin
            @(negedge clk);
            check("issue_valid", 64'(net_valid), 64'd1);
            check("issue_img", 64'(net_img == exp_img), 64'd1);
            check("issue_no_grant", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        net_ready = 1'b1;
        @(negedge clk);
        check("issue_valid", 64'(net_valid), 64'd1);
        check("issue_img", 64'(net_img == exp_img), 64'd1);
        @(posedge clk); #1;
        net_ready = 1'b0;
        if (done_wait == -2) return;
        if (done_wait == -1) begin
            sbq.push_back('{exp_oh, 8'hFF, 1'b1});
            for (int k = 0; k <= TIMEOUT; k++) begin
                @(negedge clk);
                check("abort_timing", 64'(net_abort), 64'(k == TIMEOUT));
                check("to_no_rsp", 64'(rsp_valid), 64'd0);
                @(posedge clk); #1;
            end
            return;
        end
        for (int k = 0; k < done_wait; k++) begin
            @(negedge clk);
            check("wait_no_abort", 64'(net_abort), 64'd0);
            check("wait_no_rsp", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        net_done   = 1'b1;
        net_number = num;
        sbq.push_back('{exp_oh, num, 1'b0});
        @(negedge clk);
        check("done_no_abort", 64'(net_abort), 64'd0);
        @(posedge clk); #1;
        net_done = 1'b0;
    endtask

    initial begin
        int g, gprev;
        rst_n      = 1'b0;
        req_valid  = '1;
        rsp_ready  = '1;
        net_ready  = 1'b0;
        net_done   = 1'b0;
        net_number = '0;
        for (int i = 0; i < N_REQ; i++) req_img[i*IMG_W +: IMG_W] = mk_img(i + 1);

        // Reset state, with every requester already asking.
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_number", 64'(rsp_number), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_net_img", 64'(net_img != '0), 64'd0);
        check("rst_net_valid", 64'(net_valid), 64'd0);
        check("rst_net_abort", 64'(net_abort), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All four continuously valid: order 0,1,2,3,0 at one grant per 4 cycles.
        serve(0, 1'b0, 0, 0, 8'h10, gprev);
        serve(1, 1'b0, 0, 0, 8'h21, g); check("rr_period", 64'(g - gprev), 64'd4); gprev = g;
        serve(2, 1'b0, 0, 0, 8'h32, g); check("rr_period", 64'(g - gprev), 64'd4); gprev = g;
        serve(3, 1'b0, 0, 0, 8'h43, g); check("rr_period", 64'(g - gprev), 64'd4); gprev = g;
        serve(0, 1'b0, 0, 0, 8'h54, g); check("rr_period", 64'(g - gprev), 64'd4);
        req_valid = '0;

        // Single request, image A from requester 0, result 7.
        @(posedge clk); #1;
        req_valid = 4'b0001;
        serve(0, 1'b1, 1, 2, 8'd7, g);

        // Backpressure on both sides; requester 2 waits meanwhile.
        @(posedge clk); #1;
        req_valid = 4'b0110;
        rsp_ready = 4'b1101;
        serve(1, 1'b1, 20, 3, 8'h5A, g);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
            check("bp_rsp_number", 64'(rsp_number), 64'h5A);
            check("bp_no_grant", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = '1;
        serve(2, 1'b1, 0, 1, 8'h33, g);

        // Timeout, then a late net_done that must be ignored.
        @(posedge clk); #1;
        req_valid = 4'b0001;
        serve(0, 1'b1, 0, -1, 8'h00, g);
        net_done   = 1'b1;
        net_number = 8'h11;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_done_idle", 64'(busy), 64'd0);
            check("late_done_no_rsp", 64'(rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        net_done = 1'b0;

        // net_done on exactly the timeout cycle wins.
        req_valid = 4'b0010;
        serve(1, 1'b1, 0, TIMEOUT, 8'h42, g);

        // Reset during WAIT, then requester 0 regains first priority.
        @(posedge clk); #1;
        req_valid = 4'b0100;
        serve(2, 1'b1, 0, -2, 8'h00, g);
        @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        @(posedge clk); #2;
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd0);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_rsp_number", 64'(rsp_number), 64'd0);
        check("arst_rsp_err", 64'(rsp_err), 64'd0);
        check("arst_net_img", 64'(net_img != '0), 64'd0);
        check("arst_net_valid", 64'(net_valid), 64'd0);
        check("arst_net_abort", 64'(net_abort), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        serve(0, 1'b1, 0, 1, 8'h99, g);
        serve(3, 1'b1, 2, 0, 8'h3C, g);

        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcb_infer_sched.md
# tcb_infer_sched

Round-robin inference scheduler that shares one TCB classifier network instance (121 pixels × 8 bit = 968-bit image in, 8-bit class number out) between several image requesters. It arbitrates requests, registers the granted image, issues it to the network with a valid/ready handshake and waits for the result under a watchdog. It then returns the class number to the owning requester. It sits between the image sources and the network top in the inference subsystem.

## Interface

Parameters:
- N_REQ, 4, number of requesters
- IMG_W, 968, image width in bits (121 × 8)
- NUM_W, 8, class-number width
- TIMEOUT, 1023, maximum WAIT cycles before abort; the counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester image valid
- req_img  in  N_REQ*IMG_W  requester i image at [i*IMG_W +: IMG_W]
- req_ready  out  N_REQ  one-hot accept, high only for the granted requester in IDLE
- rsp_valid  out  N_REQ  one-hot result valid for the owning requester
- rsp_number  out  NUM_W  result class; meaningful while any rsp_valid bit is high
- rsp_err  out  1  result came from a timeout
- rsp_ready  in  N_REQ  per-requester result accept
- net_img  out  IMG_W  registered image to the network
- net_valid  out  1  image offered to the network
- net_ready  in  1  network accepts the image
- net_done  in  1  one-cycle pulse; net_number is valid in that cycle
- net_number  in  NUM_W  network class output
- net_abort  out  1  one-cycle synchronous clear to the network on timeout
- busy  out  1  high in every state except IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid bit is set, the rr_arbiter grants the first requester after `last` (cyclic order).
  - req_ready[g] is asserted combinationally in the same cycle.
  - On that edge: the image register takes req_img[g], `owner` takes g, the FSM goes to ISSUE.
- **ISSUE**
  - net_valid=1 and net_img holds the image register.
  - When net_ready=1: the FSM goes to WAIT and the watchdog clears to 0.
  - The image register and net_img hold their value until the next grant.
- **WAIT**
  - The watchdog increments every cycle.
  - If net_done=1: rsp_number takes net_number, rsp_err=0, the FSM goes to RESP.
  - Else if the watchdog equals TIMEOUT: rsp_number=all-ones (ERR_NUMBER), rsp_err=1, net_abort pulses for 1 cycle, the FSM goes to RESP.
  - If net_done and the timeout occur in the same cycle, net_done wins.
- **RESP**
  - rsp_valid[owner]=1.
  - When rsp_ready[owner]=1: `last` takes owner and the FSM goes to IDLE.
  - rsp_ready bits of other requesters are ignored.
- net_done outside WAIT is ignored.
- req_valid from non-granted requesters is held off (req_ready=0) and never dropped; requesters must keep req_img stable while req_valid is high.
- Fairness: a requester that keeps req_valid high is granted within N_REQ transactions.

## Timing

- Reset (async assert, sync-safe deassert):
  - FSM=IDLE, `last`=N_REQ-1 (requester 0 has first priority).
  - Watchdog=0, image register=0.
  - Every output is 0: req_ready, rsp_valid, rsp_number, rsp_err, net_img, net_valid, net_abort, busy.
- Grant cycle C (req_ready high) → net_valid high from C+1.
- net_ready at cycle D → WAIT from D+1.
- net_done at cycle E → rsp_valid high from E+1.
- rsp_ready at cycle F → IDLE at F+1; the earliest next req_ready is F+1.
- Minimum back-to-back period with net_ready and net_done in their first possible cycles: 4 cycles per inference.
- Timeout: when WAIT entry is cycle W, the timeout fires at W+TIMEOUT and rsp_valid rises at W+TIMEOUT+1.
- Reset mid-operation: the in-flight transaction is discarded, no response is produced and net_abort stays 0. The network is reset by the shared rst_n.

## Structure

- Package tcb_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - constants IMG_W=968, NUM_W=8, ERR_NUMBER='1
- Sub-module rr_arbiter:
  - parameter N_REQ
  - inputs req[N_REQ], last index; output one-hot grant
  - purely combinational, instantiated once
- The top contains the FSM, image register, owner/last registers, watchdog and response register.

## Test plan

- Single request: req_valid=0001, img pattern A; net_ready one cycle after net_valid, net_done with net_number=7 three cycles later → rsp_valid=0001, rsp_number=7, rsp_err=0, net_img==A throughout ISSUE.
- All four requesters valid continuously after reset → grant order 0,1,2,3,0; each response goes only to its owner's rsp_valid bit.
- Backpressure: net_ready held low 20 cycles → net_valid stays high, net_img stable, no req_ready pulses; rsp_ready held low 10 cycles → rsp_valid and rsp_number stable, no new grant.
- Timeout with TIMEOUT=15: net_done never arrives → rsp_err=1, rsp_number=8'hFF, a single net_abort pulse exactly 15 cycles after WAIT entry; a late net_done afterwards is ignored.
- net_done coinciding with the timeout cycle → rsp_err=0 and net_number is returned; no net_abort pulse.
- rst_n asserted during WAIT → all outputs 0 asynchronously; after release, requester 0 has priority and the next transaction completes normally.
